// File: rtl/water_detection_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// water_detection_pkg : shared FSM type, 7-segment constants and helpers
// Rev 1.0
// ----------------------------------------------------------------------------
package water_detection_pkg;

    localparam int DEF_SCAN_DIV     = 1;
    localparam int DEF_IDLE_TIMEOUT = 12;
    localparam int DEF_THRESH       = 50;
    localparam int DEF_BEEP_DIV     = 2;

    localparam logic [6:0] CNT_MAX     = 7'd99;
    localparam logic [3:0] DIGIT_BLANK = 4'hF;

    // Segment order {g,f,e,d,c,b,a}, active-high
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } batch_state_e;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

    // Returns {tens, units} for a value in 0..99
    function automatic logic [7:0] to_bcd(input logic [6:0] v);
        return {4'(v / 7'd10), 4'(v % 7'd10)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/water_detection_sys_display.sv
`default_nettype none
// ----------------------------------------------------------------------------
// wd_display_scan : digit/matrix scan index, select/row/dp and 7-seg decode
// Rev 1.0
// ----------------------------------------------------------------------------
module wd_display_scan
    import water_detection_pkg::*;
#(
    parameter int SCAN_DIV = DEF_SCAN_DIV
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] digits,
    input  logic [3:0]  bar,
    input  logic        alarm,
    output logic [6:0]  segment7,
    output logic        dp,
    output logic [7:0]  select,
    output logic [7:0]  row,
    output logic [7:0]  green_led,
    output logic [7:0]  red_led
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [DW-1:0] div_q, div_d;
    logic [2:0]    k_q, k_d;
    logic          step;
    logic          lit;
    logic [3:0]    digit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
            k_q   <= 3'd0;
        end else begin
            div_q <= div_d;
            k_q   <= k_d;
        end
    end

    always_comb begin
        step  = (div_q == DW'(SCAN_DIV - 1));
        div_d = step ? '0 : div_q + 1'b1;
        k_d   = step ? k_q + 3'd1 : k_q;
    end

    // Digit k and matrix row k are scanned together
    always_comb begin
        select    = ~(8'd1 << k_q);
        row       = ~(8'd1 << k_q);
        digit     = digits[{k_q, 2'b00} +: 4];
        segment7  = seg_decode(digit);
        dp        = (k_q == 3'd2);
        lit       = ({1'b0, k_q} < bar);
        green_led = (lit && !alarm) ? 8'hFF : 8'h00;
        red_led   = (lit &&  alarm) ? 8'hFF : 8'h00;
    end

endmodule
`default_nettype wire

// File: rtl/water_detection_sys.sv
`default_nettype none
// ----------------------------------------------------------------------------
// water_detection_sys : sensor pulse batching, level total, alarm and display
// Rev 1.0
// ----------------------------------------------------------------------------
module water_detection_sys
    import water_detection_pkg::*;
#(
    parameter int SCAN_DIV     = DEF_SCAN_DIV,
    parameter int IDLE_TIMEOUT = DEF_IDLE_TIMEOUT,
    parameter int THRESH       = DEF_THRESH,
    parameter int BEEP_DIV     = DEF_BEEP_DIV
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn0,
    input  logic       btn7,
    input  logic [3:0] row_in,
    output logic [3:0] col,
    output logic [6:0] segment7,
    output logic       dp,
    output logic [7:0] select,
    output logic [7:0] row,
    output logic [7:0] green_led,
    output logic [7:0] red_led,
    output logic       beep
);

    localparam int IW = $clog2(IDLE_TIMEOUT + 1);
    localparam int BW = (BEEP_DIV > 1) ? $clog2(BEEP_DIV) : 1;

    logic [3:0]    row_s1_q, row_s1_d, row_s2_q, row_s2_d, row_s3_q, row_s3_d;
    logic [1:0]    btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d, btn_s3_q, btn_s3_d;
    logic [3:0]    col_q, col_d;
    batch_state_e  state_q, state_d;
    logic [6:0]    cnt_q, cnt_d, batch_q, batch_d, total_q, total_d;
    logic [3:0]    batch_num_q, batch_num_d;
    logic [IW-1:0] idle_q, idle_d;
    logic          ack_q, ack_d, phase_q, phase_d;
    logic [BW-1:0] beep_cnt_q, beep_cnt_d;

    logic       ev, btn0_rise, clr, alarm, timeout_hit;
    logic       start_batch, bump_cnt, close_batch, idle_tick;
    logic [7:0] sum;
    logic [3:0] bar;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_s1_q    <= 4'hF;
            row_s2_q    <= 4'hF;
            row_s3_q    <= 4'hF;
            btn_s1_q    <= 2'b00;
            btn_s2_q    <= 2'b00;
            btn_s3_q    <= 2'b00;
            col_q       <= 4'b1110;
            state_q     <= IDLE;
            cnt_q       <= 7'd0;
            batch_q     <= 7'd0;
            total_q     <= 7'd0;
            batch_num_q <= 4'd0;
            idle_q      <= '0;
            ack_q       <= 1'b0;
            phase_q     <= 1'b0;
            beep_cnt_q  <= '0;
        end else begin
            row_s1_q    <= row_s1_d;
            row_s2_q    <= row_s2_d;
            row_s3_q    <= row_s3_d;
            btn_s1_q    <= btn_s1_d;
            btn_s2_q    <= btn_s2_d;
            btn_s3_q    <= btn_s3_d;
            col_q       <= col_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            batch_q     <= batch_d;
            total_q     <= total_d;
            batch_num_q <= batch_num_d;
            idle_q      <= idle_d;
            ack_q       <= ack_d;
            phase_q     <= phase_d;
            beep_cnt_q  <= beep_cnt_d;
        end
    end

    // Synchronizers (stage 3 holds the previous value for edge detection)
    always_comb begin
        row_s1_d    = row_in;
        row_s2_d    = row_s1_q;
        row_s3_d    = row_s2_q;
        btn_s1_d    = {btn7, btn0};
        btn_s2_d    = btn_s1_q;
        btn_s3_d    = btn_s2_q;
        col_d       = {col_q[2:0], col_q[3]};
        ev          = (row_s3_q == 4'hF) && (row_s2_q != 4'hF);
        btn0_rise   = btn_s2_q[0] & ~btn_s3_q[0];
        clr         = btn_s2_q[1] & ~btn_s3_q[1];
        alarm       = (total_q >= 7'(THRESH));
        timeout_hit = (idle_q == IW'(IDLE_TIMEOUT - 1));
    end

    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (ev) state_d = COUNT;
                COUNT:   if (!ev && timeout_hit) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // An event in the timeout cycle keeps the batch open
    always_comb begin
        start_batch = !clr && (state_q == IDLE)  && ev;
        bump_cnt    = !clr && (state_q == COUNT) && ev;
        close_batch = !clr && (state_q == COUNT) && !ev && timeout_hit;
        idle_tick   = !clr && (state_q == COUNT) && !ev && !timeout_hit;
    end

    always_comb begin
        cnt_d       = cnt_q;
        batch_d     = batch_q;
        total_d     = total_q;
        batch_num_d = batch_num_q;
        idle_d      = idle_q;
        sum         = {1'b0, total_q} + {1'b0, cnt_q};
        if (clr) begin
            cnt_d       = 7'd0;
            batch_d     = 7'd0;
            total_d     = 7'd0;
            batch_num_d = 4'd0;
            idle_d      = '0;
        end else if (start_batch) begin
            cnt_d  = 7'd1;
            idle_d = '0;
        end else if (bump_cnt) begin
            cnt_d  = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 7'd1;
            idle_d = '0;
        end else if (close_batch) begin
            batch_d     = cnt_q;
            total_d     = (sum > {1'b0, CNT_MAX}) ? CNT_MAX : sum[6:0];
            batch_num_d = (batch_num_q == 4'd9) ? 4'd0 : batch_num_q + 4'd1;
            cnt_d       = 7'd0;
            idle_d      = '0;
        end else if (idle_tick) begin
            idle_d = idle_q + 1'b1;
        end
    end

    // Acknowledge only counts against an alarm already raised
    always_comb begin
        ack_d      = !clr && alarm && (ack_q || btn0_rise);
        beep_cnt_d = (beep_cnt_q == BW'(BEEP_DIV - 1)) ? '0 : beep_cnt_q + 1'b1;
        phase_d    = (beep_cnt_q == BW'(BEEP_DIV - 1)) ? ~phase_q : phase_q;
        bar        = (total_q[6:3] > 4'd8) ? 4'd8 : total_q[6:3];
    end

    assign beep = alarm & ~ack_q & phase_q;
    assign col  = col_q;

    wd_display_scan #(
        .SCAN_DIV (SCAN_DIV)
    ) u_display (
        .clk       (clk),
        .rst_n     (rst_n),
        .digits    ({batch_num_q, {3{DIGIT_BLANK}}, to_bcd(batch_q), to_bcd(total_q)}),
        .bar       (bar),
        .alarm     (alarm),
        .segment7  (segment7),
        .dp        (dp),
        .select    (select),
        .row       (row),
        .green_led (green_led),
        .red_led   (red_led)
    );

endmodule
`default_nettype wire

// File: tb/tb_water_detection_sys.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// tb_water_detection_sys : scoreboard bench with a batch-level reference model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_water_detection_sys;

    localparam int IDLE_TIMEOUT = 12;
    localparam int THRESH       = 50;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b1;
    logic       btn0   = 1'b0;
    logic       btn7   = 1'b0;
    logic [3:0] row_in = 4'hF;
    logic [3:0] col;
    logic [6:0] segment7;
    logic       dp;
    logic [7:0] select, row, green_led, red_led;
    logic       beep;

    always #5 clk = ~clk;

    water_detection_sys #(
        .SCAN_DIV     (1),
        .IDLE_TIMEOUT (IDLE_TIMEOUT),
        .THRESH       (THRESH),
        .BEEP_DIV     (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn0      (btn0),
        .btn7      (btn7),
        .row_in    (row_in),
        .col       (col),
        .segment7  (segment7),
        .dp        (dp),
        .select    (select),
        .row       (row),
        .green_led (green_led),
        .red_led   (red_led),
        .beep      (beep)
    );

    typedef struct packed {
        logic [7:0][6:0] seg;
        logic [3:0]      bar;
        logic            alarm;
        logic            beeping;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests  = 0;
    int   n_fail   = 0;
    bit   mon_busy = 1'b0;

    // Reference model: state visible after each closed batch / button action
    int m_total = 0;
    int m_batch = 0;
    int m_bn    = 0;
    bit m_ack   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0:       return 7'b0111111;
            1:       return 7'b0000110;
            2:       return 7'b1011011;
            3:       return 7'b1001111;
            4:       return 7'b1100110;
            5:       return 7'b1101101;
            6:       return 7'b1111101;
            7:       return 7'b0000111;
            8:       return 7'b1111111;
            9:       return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic void model_close(input int n);
        int c = (n > 99) ? 99 : n;
        m_batch = c;
        m_total = (m_total + c > 99) ? 99 : m_total + c;
        m_bn    = (m_bn + 1) % 10;
    endfunction

    function automatic void model_clear();
        m_total = 0;
        m_batch = 0;
        m_bn    = 0;
        m_ack   = 1'b0;
    endfunction

    function automatic void push_exp();
        exp_t e;
        e.seg[0]  = seg_of(m_total % 10);
        e.seg[1]  = seg_of(m_total / 10);
        e.seg[2]  = seg_of(m_batch % 10);
        e.seg[3]  = seg_of(m_batch / 10);
        e.seg[4]  = 7'd0;
        e.seg[5]  = 7'd0;
        e.seg[6]  = 7'd0;
        e.seg[7]  = seg_of(m_bn);
        e.bar     = 4'((m_total / 8 > 8) ? 8 : m_total / 8);
        e.alarm   = (m_total >= THRESH);
        e.beeping = e.alarm && !m_ack;
        exp_q.push_back(e);
    endfunction

    // Monitor: one full scan cycle per expected record
    always begin : monitor
        exp_t       e;
        logic [3:0] pcol;
        logic [7:0] seen, exp_sel, exp_lit, bs;
        bit         tog_ok;
        int         k;
        @(negedge clk);
        if (exp_q.size() > 0) begin
            mon_busy = 1'b1;
            e    = exp_q.pop_front();
            seen = 8'd0;
            pcol = col;
            bs   = 8'd0;
            for (int i = 0; i < 8; i++) begin
                if (i > 0) @(negedge clk);
                k = 0;
                for (int j = 0; j < 8; j++) if (!select[j]) k = j;
                exp_sel = ~(8'd1 << k);
                seen[k] = 1'b1;
                check("scan_select_row", {select, row}, {exp_sel, exp_sel});
                check("segment7", segment7, e.seg[k]);
                check("dp", dp, (k == 2));
                exp_lit = (k < e.bar) ? 8'hFF : 8'h00;
                check("matrix_green_red", {green_led, red_led},
                      e.alarm ? {8'h00, exp_lit} : {exp_lit, 8'h00});
                if (i > 0) check("col_rotate", col, {pcol[2:0], pcol[3]});
                pcol  = col;
                bs[i] = beep;
            end
            check("scan_cover", seen, 8'hFF);
            if (e.beeping) begin
                tog_ok = 1'b1;
                for (int i = 2; i < 8; i++) if (bs[i] == bs[i-2]) tog_ok = 1'b0;
                check("beep_toggle", {bs, 7'd0, tog_ok}, {bs, 7'd0, 1'b1});
            end else begin
                check("beep_off", bs, 8'h00);
            end
            mon_busy = 1'b0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_mon();
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !mon_busy) return;
        end
        n_tests++;
        n_fail++;
        $display("FAIL monitor_wait: got busy, expected idle within 100 clocks");
    endtask

    task automatic expect_state();
        push_exp();
        wait_mon();
    endtask

    task automatic pulse_event(input int low, input int high);
        row_in = 4'($urandom_range(0, 14));
        tick(low);
        row_in = 4'hF;
        tick(high);
    endtask

    // Consecutive counted events at most IDLE_TIMEOUT clocks apart stay in one batch
    task automatic run_batch(input int n, input int low, input int high, input bit rnd);
        int lo, hi;
        for (int i = 0; i < n; i++) begin
            lo = low;
            hi = high;
            if (rnd) begin
                lo = $urandom_range(1, 2);
                hi = $urandom_range(1, IDLE_TIMEOUT - lo);
            end
            pulse_event(lo, hi);
        end
        tick(IDLE_TIMEOUT + 8);
        model_close(n);
    endtask

    task automatic press_btn0(input int hold);
        btn0 = 1'b1;
        tick(hold);
        btn0 = 1'b0;
        tick(4);
        if (m_total >= THRESH) m_ack = 1'b1;
    endtask

    task automatic press_btn7();
        btn7 = 1'b1;
        tick(2);
        btn7 = 1'b0;
        tick(4);
        model_clear();
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish before 2000000 ns");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int r;
        #1 rst_n = 1'b0;
        #2;
        check("reset_col", col, 4'b1110);
        check("reset_select", select, 8'b1111_1110);
        check("reset_row", row, 8'b1111_1110);
        check("reset_segment7", segment7, 7'h3F);
        check("reset_dp", dp, 1'b0);
        check("reset_green", green_led, 8'h00);
        check("reset_red", red_led, 8'h00);
        check("reset_beep", beep, 1'b0);
        tick(3);
        rst_n = 1'b1;
        tick(2);
        expect_state();

        run_batch(32, 1, 3, 1'b0);
        expect_state();
        run_batch(32, 1, 3, 1'b0);
        expect_state();
        press_btn0(20);
        expect_state();
        press_btn7();
        expect_state();
        press_btn0(3);
        expect_state();
        run_batch(60, 1, 3, 1'b0);
        expect_state();
        run_batch(105, 1, 1, 1'b0);
        expect_state();

        // Event landing exactly on the timeout keeps the batch open
        press_btn7();
        for (int i = 0; i < 3; i++) pulse_event(1, IDLE_TIMEOUT - 1);
        tick(IDLE_TIMEOUT + 8);
        model_close(3);
        expect_state();
        // One clock later the batch has already closed
        pulse_event(1, IDLE_TIMEOUT);
        model_close(1);
        pulse_event(1, IDLE_TIMEOUT);
        tick(IDLE_TIMEOUT + 8);
        model_close(1);
        expect_state();

        // Clear on the timeout clock
        pulse_event(1, 3);
        pulse_event(1, IDLE_TIMEOUT - 1);
        btn7 = 1'b1;
        tick(2);
        btn7 = 1'b0;
        tick(IDLE_TIMEOUT + 8);
        model_clear();
        expect_state();

        // Acknowledge on the clock where the alarm is raised is ignored
        for (int i = 0; i < 49; i++) pulse_event(1, 1);
        pulse_event(1, IDLE_TIMEOUT - 1);
        btn0 = 1'b1;
        tick(2);
        btn0 = 1'b0;
        tick(IDLE_TIMEOUT + 8);
        model_close(50);
        expect_state();

        // Reset in the middle of a batch
        press_btn7();
        for (int i = 0; i < 5; i++) pulse_event(1, 2);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
        model_clear();
        run_batch(3, 1, 2, 1'b0);
        expect_state();

        // Batch number wraps 9 -> 0
        for (int i = 0; i < 11; i++) run_batch(1, 1, 1, 1'b0);
        expect_state();

        for (int it = 0; it < 14; it++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      press_btn7();
            else if (r < 3)  press_btn0($urandom_range(1, 20));
            else             run_batch($urandom_range(1, 35), 1, 1, 1'b1);
            expect_state();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
